// File: rtl/hpc_event_reporter.sv
// -----------------------------------------------------------------------------
// hpc_event_reporter
//
// Watches the writeback (retire) stage of the single-issue in-order core and
// produces one classified, single-cycle report per retired instruction for
// the performance-counter unit. Each retired instruction is held until the
// next one retires, because only then is its true next PC known. On drain
// (halt / end of program) the held instruction is flushed with next_pc=pc+4.
// The bus also carries per-cycle stall-cause levels.
//
// Ports:
//   clk, rst_i            core clock, asynchronous active-low reset
//   wb_valid, wb_stall    WB occupancy / hold (held instr is re-presented)
//   wb_stall_alu/_mem     stall cause qualifiers
//   wb_pc, wb_inst        PC and instruction word in WB
//   drain                 flush the held instruction
//   req_*                 registered report fields (idle: RESET_PC / 0)
//   stall_by_ALU/_MEM     registered stall-cause levels, one cycle delayed
//   busy                  an instruction is held and not yet reported
// -----------------------------------------------------------------------------
module hpc_event_reporter #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        wb_valid,
  input  logic        wb_stall,
  input  logic        wb_stall_alu,
  input  logic        wb_stall_mem,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_inst,
  input  logic        drain,
  output logic [31:0] req_pc,
  output logic [31:0] req_next_pc,
  output logic [31:0] req_inst_opcode,
  output logic        req_inst_valid,
  output logic        req_inst_commit,
  output logic        req_inst_retired,
  output logic        req_inst_ALU,
  output logic        req_inst_div,
  output logic        req_inst_mul,
  output logic        req_inst_load,
  output logic        req_inst_store,
  output logic        req_inst_branch,
  output logic        req_branch_taken,
  output logic [31:0] req_branch_inst_pc,
  output logic [31:0] req_branch_target,
  output logic        stall_by_ALU,
  output logic        stall_by_MEM,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Class vector bit positions: {alu, div, mul, load, store, branch}
  localparam int CLS_ALU    = 5;
  localparam int CLS_DIV    = 4;
  localparam int CLS_MUL    = 3;
  localparam int CLS_LOAD   = 2;
  localparam int CLS_STORE  = 1;
  localparam int CLS_BRANCH = 0;

  // Decode the major opcode into the class vector; jal/jalr/system/unknown
  // instructions are reported with no class flag set.
  function automatic logic [5:0] classify(input logic [31:0] inst);
    logic [5:0] cls;
    cls = 6'b00_0000;
    case (inst[6:0])
      7'b011_0011: begin
        // M-extension shares the OP opcode; funct3[2] splits mul from div
        if (inst[31:25] == 7'b000_0001) begin
          if (inst[14]) begin
            cls[CLS_DIV] = 1'b1;
          end else begin
            cls[CLS_MUL] = 1'b1;
          end
        end else begin
          cls[CLS_ALU] = 1'b1;
        end
      end
      7'b001_0011: cls[CLS_ALU]    = 1'b1;
      7'b011_0111: cls[CLS_ALU]    = 1'b1;
      7'b001_0111: cls[CLS_ALU]    = 1'b1;
      7'b000_0011: cls[CLS_LOAD]   = 1'b1;
      7'b010_0011: cls[CLS_STORE]  = 1'b1;
      7'b110_0011: cls[CLS_BRANCH] = 1'b1;
      default:     cls             = 6'b00_0000;
    endcase
    return cls;
  endfunction

  // Sign-extended B-type immediate (bit 0 always zero).
  function automatic logic [31:0] b_imm(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  state_t      state_r;
  logic [31:0] held_pc_r;
  logic [31:0] held_inst_r;

  logic [31:0] pc_r;
  logic [31:0] next_pc_r;
  logic [31:0] opcode_r;
  logic        valid_r;
  logic [5:0]  cls_r;
  logic        taken_r;
  logic [31:0] bpc_r;
  logic [31:0] target_r;
  logic        stall_alu_r;
  logic        stall_mem_r;
  logic        busy_r;

  logic        capture_s;
  logic        fire_s;
  logic [31:0] next_pc_s;
  logic [31:0] held_pc_plus4_s;
  logic [5:0]  cls_s;
  logic        is_branch_s;
  logic        taken_s;
  logic [31:0] target_s;

  assign capture_s       = wb_valid & ~wb_stall;
  assign held_pc_plus4_s = held_pc_r + 32'd4;
  assign cls_s           = classify(held_inst_r);
  assign is_branch_s     = cls_s[CLS_BRANCH];
  assign target_s        = held_pc_r + b_imm(held_inst_r);
  assign taken_s         = is_branch_s & (next_pc_s != held_pc_plus4_s);

  // Decide whether the held instruction is reported this cycle and with
  // which next PC: a new retirement supplies it directly, a drain implies
  // sequential fall-through.
  always_comb begin
    fire_s    = 1'b0;
    next_pc_s = RESET_PC;
    case (state_r)
      ST_EMPTY: begin
        fire_s    = 1'b0;
        next_pc_s = RESET_PC;
      end
      ST_HOLD: begin
        if (capture_s) begin
          fire_s    = 1'b1;
          next_pc_s = wb_pc;
        end else if (drain) begin
          fire_s    = 1'b1;
          next_pc_s = held_pc_plus4_s;
        end else begin
          fire_s    = 1'b0;
          next_pc_s = RESET_PC;
        end
      end
      ST_FLUSH: begin
        fire_s    = 1'b1;
        next_pc_s = held_pc_plus4_s;
      end
      default: begin
        fire_s    = 1'b0;
        next_pc_s = RESET_PC;
      end
    endcase
  end

  // Hold FSM together with the registered report fields; every report field
  // returns to its idle value on any cycle without a report.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= ST_EMPTY;
      held_pc_r   <= RESET_PC;
      held_inst_r <= 32'h0000_0000;
      busy_r      <= 1'b0;
      pc_r        <= RESET_PC;
      next_pc_r   <= RESET_PC;
      opcode_r    <= 32'h0000_0000;
      valid_r     <= 1'b0;
      cls_r       <= 6'b00_0000;
      taken_r     <= 1'b0;
      bpc_r       <= RESET_PC;
      target_r    <= RESET_PC;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (capture_s) begin
            held_pc_r   <= wb_pc;
            held_inst_r <= wb_inst;
            state_r     <= drain ? ST_FLUSH : ST_HOLD;
            busy_r      <= 1'b1;
          end else begin
            state_r <= ST_EMPTY;
            busy_r  <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (capture_s) begin
            held_pc_r   <= wb_pc;
            held_inst_r <= wb_inst;
            state_r     <= drain ? ST_FLUSH : ST_HOLD;
            busy_r      <= 1'b1;
          end else if (drain) begin
            state_r <= ST_EMPTY;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_HOLD;
            busy_r  <= 1'b1;
          end
        end
        ST_FLUSH: begin
          // Core is halted: anything still arriving in WB is discarded.
          state_r <= ST_EMPTY;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_EMPTY;
          busy_r  <= 1'b0;
        end
      endcase

      if (fire_s) begin
        pc_r      <= held_pc_r;
        next_pc_r <= next_pc_s;
        opcode_r  <= held_inst_r;
        valid_r   <= 1'b1;
        cls_r     <= cls_s;
        taken_r   <= taken_s;
        bpc_r     <= is_branch_s ? held_pc_r : RESET_PC;
        target_r  <= is_branch_s ? target_s : RESET_PC;
      end else begin
        pc_r      <= RESET_PC;
        next_pc_r <= RESET_PC;
        opcode_r  <= 32'h0000_0000;
        valid_r   <= 1'b0;
        cls_r     <= 6'b00_0000;
        taken_r   <= 1'b0;
        bpc_r     <= RESET_PC;
        target_r  <= RESET_PC;
      end
    end
  end

  // Stall-cause levels are independent of the hold FSM.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      stall_alu_r <= 1'b0;
      stall_mem_r <= 1'b0;
    end else begin
      stall_alu_r <= wb_valid & wb_stall & wb_stall_alu;
      stall_mem_r <= wb_valid & wb_stall & wb_stall_mem;
    end
  end

  assign req_pc             = pc_r;
  assign req_next_pc        = next_pc_r;
  assign req_inst_opcode    = opcode_r;
  assign req_inst_valid     = valid_r;
  assign req_inst_commit    = valid_r;
  assign req_inst_retired   = valid_r;
  assign req_inst_ALU       = cls_r[CLS_ALU];
  assign req_inst_div       = cls_r[CLS_DIV];
  assign req_inst_mul       = cls_r[CLS_MUL];
  assign req_inst_load      = cls_r[CLS_LOAD];
  assign req_inst_store     = cls_r[CLS_STORE];
  assign req_inst_branch    = cls_r[CLS_BRANCH];
  assign req_branch_taken   = taken_r;
  assign req_branch_inst_pc = bpc_r;
  assign req_branch_target  = target_r;
  assign stall_by_ALU       = stall_alu_r;
  assign stall_by_MEM       = stall_mem_r;
  assign busy               = busy_r;

endmodule

// File: doc/hpc_event_reporter.md
Name: hpc_event_reporter

Overview:
- Pipeline-side producer of the performance-counter request interface.
- Observes the writeback (retire) stage of the single-issue in-order core.
- Holds each retired instruction until the next one retires, so that its true next PC is known.
- Emits exactly one classified, single-cycle report per retired instruction to the HPC unit, plus per-cycle stall-cause levels.

Parameters:
- RESET_PC, 32'h0000_0000, value driven on PC/target outputs while idle and after reset.

Ports:
- clk  in  1  core clock
- rst_i  in  1  asynchronous active-low reset
- wb_valid  in  1  instruction present in WB this cycle
- wb_stall  in  1  WB held; the same instruction is re-presented next cycle
- wb_stall_alu  in  1  stall cause is a multi-cycle ALU op (mul/div)
- wb_stall_mem  in  1  stall cause is a memory access
- wb_pc  in  32  PC of the WB instruction
- wb_inst  in  32  instruction word in WB
- drain  in  1  halt/end of program; flush the held instruction
- req_pc  out  32  PC of the reported instruction
- req_next_pc  out  32  PC of the next retired instruction, or pc+4 on drain
- req_inst_opcode  out  32  full instruction word
- req_inst_valid  out  1  one-cycle report strobe
- req_inst_commit, req_inst_retired  out  1 each  equal to req_inst_valid (in-order, single issue)
- req_inst_ALU, req_inst_div, req_inst_mul  out  1 each  class flags
- req_inst_load, req_inst_store, req_inst_branch  out  1 each  class flags
- req_branch_taken  out  1  branch resolved taken
- req_branch_inst_pc  out  32  equal to req_pc when req_inst_branch, else RESET_PC
- req_branch_target  out  32  pc + sign-extended B-immediate when branch, else RESET_PC
- stall_by_ALU, stall_by_MEM  out  1 each  registered stall-cause levels
- busy  out  1  an instruction is held, unreported

Behaviour:
- Capture event: wb_valid=1 and wb_stall=0. A stalled instruction is captured once, on its final non-stalled cycle.
- FSM states:
  - EMPTY: nothing held; busy=0.
  - HOLD: one instruction held (pc, inst); busy=1.
  - FLUSH: one instruction held, final drain pending; busy=1.
- EMPTY:
  - capture -> HOLD.
  - drain alone -> stays EMPTY, no report.
  - capture+drain -> FLUSH.
- HOLD:
  - capture -> report held instruction with next_pc=wb_pc; store new instruction; stay HOLD.
  - drain alone -> report with next_pc=held_pc+4; -> EMPTY.
  - capture+drain -> report held with next_pc=wb_pc; store new; -> FLUSH.
- FLUSH:
  - Report held instruction with next_pc=held_pc+4 -> EMPTY.
  - Captures arriving in FLUSH are discarded (the core is halted).
- Latency: a report is registered and appears the cycle after the event that supplies its next_pc. Output fields are registered together.
- req_inst_valid is high for exactly one cycle per report. When it is low, all class flags and req_branch_taken are 0 and all 32-bit fields equal RESET_PC; req_inst_opcode is 0.
- Classification uses inst[6:0]:
  - 0110011 with funct7=0000001: mul when funct3[2]=0; div when funct3[2]=1. ALU=0.
  - 0110011 otherwise, 0010011, 0110111, 0010111: ALU.
  - 0000011: load. 0100011: store. 1100011: branch.
  - jal/jalr/system/unknown: report with no class flag set.
- Branch arithmetic:
  - taken = (next_pc != pc+4).
  - target = pc + {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}, mod 2^32.
  - pc+4 wraps mod 2^32 (32'hFFFF_FFFC+4=0).
- stall_by_ALU <= wb_valid & wb_stall & wb_stall_alu; stall_by_MEM likewise with wb_stall_mem. Both are levels, one-cycle delayed, and independent of the FSM; both may be high together.
- Reset (any time, asynchronous): state EMPTY, held data cleared, all outputs at their idle values (RESET_PC / 0). An instruction held at reset is never reported.

Test Plan:
- Three back-to-back captures, pc 0x0,0x4,0x8 (addi), then drain → reports at cycles 2,3 and on drain+1: (0x0→0x4),(0x4→0x8),(0x8→0xC); ALU=1 each; no extra strobes.
- beq at 0x10 with imm=+0x20, next capture pc 0x30 → branch=1, taken=1, target=0x30, branch_inst_pc=0x10. Repeat with next pc 0x14 → taken=0, target still 0x30.
- div (funct7=1, funct3=100) stalled 5 cycles with wb_stall_alu → stall_by_ALU high 5 cycles, delayed 1. Single report with div=1, mul=0, ALU=0; no duplicate reports.
- capture pc 0x40 while HOLD(0x3C) with drain asserted the same cycle → report (0x3C→0x40), then next cycle (0x40→0x44); then EMPTY; busy=0.
- rst_i low while HOLD(pc 0x100), mid-stream → outputs zero/RESET_PC immediately. No report of 0x100 after release. Next capture behaves as from EMPTY.
- lw at 0xFFFF_FFFC, then drain → load=1, req_next_pc=0x0000_0000 (wrap).
